// File: rtl/vga_timing_pkg.sv
// Shared timing constants, polarity codes and helpers for the VGA timing generator.
package vga_timing_pkg;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // 640x480@60
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;

    // 800x600@72
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FRONT  = 56;
    localparam int VGA800_H_SYNC   = 120;
    localparam int VGA800_H_BACK   = 64;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FRONT  = 37;
    localparam int VGA800_V_SYNC   = 6;
    localparam int VGA800_V_BACK   = 23;

    function automatic int axis_total(input int active, input int front, input int sync, input int back);
        return active + front + sync + back;
    endfunction

    function automatic bit axis_cfg_ok(input int active, input int front, input int sync, input int back,
                                       input int counter_size);
        return (active > 0) && (front > 0) && (sync > 0) && (back > 0) &&
               (axis_total(active, front, sync, back) <= (1 << counter_size));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with registered sync/active flags derived
// from the next position, so flags and position always agree.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE       = VGA640_H_ACTIVE,
    parameter int   FRONT        = VGA640_H_FRONT,
    parameter int   SYNC         = VGA640_H_SYNC,
    parameter int   BACK         = VGA640_H_BACK,
    parameter logic POL          = SYNC_ACTIVE_LOW,
    parameter int   COUNTER_SIZE = 11
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic                    step,
    output logic [COUNTER_SIZE-1:0] pos,
    output logic                    sync,
    output logic                    active,
    output logic                    wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    generate
        if (!axis_cfg_ok(ACTIVE, FRONT, SYNC, BACK, COUNTER_SIZE)) begin : g_cfg_err
            $error("vga_axis_counter: zero-length segment or total exceeds counter range");
        end
    endgenerate

    localparam logic [COUNTER_SIZE-1:0] LAST       = COUNTER_SIZE'(TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] ACTIVE_END = COUNTER_SIZE'(ACTIVE);
    localparam logic [COUNTER_SIZE-1:0] SYNC_START = COUNTER_SIZE'(ACTIVE + FRONT);
    localparam logic [COUNTER_SIZE-1:0] SYNC_END   = COUNTER_SIZE'(ACTIVE + FRONT + SYNC);

    logic [COUNTER_SIZE-1:0] r_pos;
    logic                    r_sync;
    logic                    r_active;
    logic [COUNTER_SIZE-1:0] w_next;
    logic                    w_wrap;

    assign w_wrap = (r_pos == LAST);
    assign w_next = w_wrap ? '0 : r_pos + COUNTER_SIZE'(1);

    // Reset parks on the last back-porch position so the first step lands on 0.
    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            r_pos    <= LAST;
            r_sync   <= ~POL;
            r_active <= 1'b0;
        end else if (step) begin
            r_pos    <= w_next;
            r_sync   <= ((w_next >= SYNC_START) && (w_next < SYNC_END)) ? POL : ~POL;
            r_active <= (w_next < ACTIVE_END);
        end
    end

    assign pos    = r_pos;
    assign sync   = r_sync;
    assign active = r_active;
    assign wrap   = w_wrap;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA sync/position generator: horizontal axis steps on enable, vertical axis
// steps when the horizontal axis wraps; strobes registered alongside position.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int   COUNTER_SIZE = 11,
    parameter int   H_ACTIVE     = VGA640_H_ACTIVE,
    parameter int   H_FRONT      = VGA640_H_FRONT,
    parameter int   H_SYNC       = VGA640_H_SYNC,
    parameter int   H_BACK       = VGA640_H_BACK,
    parameter int   V_ACTIVE     = VGA640_V_ACTIVE,
    parameter int   V_FRONT      = VGA640_V_FRONT,
    parameter int   V_SYNC       = VGA640_V_SYNC,
    parameter int   V_BACK       = VGA640_V_BACK,
    parameter logic H_SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter logic V_SYNC_POL   = SYNC_ACTIVE_LOW
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    display_enable,
    output logic [COUNTER_SIZE-1:0] h_pos,
    output logic [COUNTER_SIZE-1:0] v_pos,
    output logic                    line_start,
    output logic                    frame_start
);

    logic w_h_wrap, w_v_wrap, w_h_active, w_v_active, w_v_step;
    logic r_line_start, r_frame_start;

    assign w_v_step = enable & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(H_SYNC_POL), .COUNTER_SIZE(COUNTER_SIZE)
    ) u_h_axis (
        .control_clock(control_clock), .reset(reset), .step(enable),
        .pos(h_pos), .sync(h_sync), .active(w_h_active), .wrap(w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(V_SYNC_POL), .COUNTER_SIZE(COUNTER_SIZE)
    ) u_v_axis (
        .control_clock(control_clock), .reset(reset), .step(w_v_step),
        .pos(v_pos), .sync(v_sync), .active(w_v_active), .wrap(w_v_wrap)
    );

    // Next h_pos is 0 exactly when h wraps; next v_pos is 0 when both wrap together.
    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (enable) begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap & w_v_wrap;
        end
    end

    assign display_enable = w_h_active & w_v_active;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three instances (640x480 low-pol, 800x600 high-pol,
// and a tiny mode filling a 4-bit counter) checked every cycle against a position model.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    logic        u0_hs, u0_vs, u0_de, u0_ls, u0_fs;
    logic [10:0] u0_hp, u0_vp;
    logic        u1_hs, u1_vs, u1_de, u1_ls, u1_fs;
    logic [10:0] u1_hp, u1_vp;
    logic        u2_hs, u2_vs, u2_de, u2_ls, u2_fs;
    logic [3:0]  u2_hp, u2_vp;

    vga_timing_generator u0 (
        .control_clock(clk), .reset(rst), .enable(en),
        .h_sync(u0_hs), .v_sync(u0_vs), .display_enable(u0_de),
        .h_pos(u0_hp), .v_pos(u0_vp), .line_start(u0_ls), .frame_start(u0_fs)
    );

    vga_timing_generator #(
        .COUNTER_SIZE(11),
        .H_ACTIVE(VGA800_H_ACTIVE), .H_FRONT(VGA800_H_FRONT), .H_SYNC(VGA800_H_SYNC), .H_BACK(VGA800_H_BACK),
        .V_ACTIVE(VGA800_V_ACTIVE), .V_FRONT(VGA800_V_FRONT), .V_SYNC(VGA800_V_SYNC), .V_BACK(VGA800_V_BACK),
        .H_SYNC_POL(SYNC_ACTIVE_HIGH), .V_SYNC_POL(SYNC_ACTIVE_HIGH)
    ) u1 (
        .control_clock(clk), .reset(rst), .enable(en),
        .h_sync(u1_hs), .v_sync(u1_vs), .display_enable(u1_de),
        .h_pos(u1_hp), .v_pos(u1_vp), .line_start(u1_ls), .frame_start(u1_fs)
    );

    vga_timing_generator #(
        .COUNTER_SIZE(4),
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .H_SYNC_POL(SYNC_ACTIVE_HIGH), .V_SYNC_POL(SYNC_ACTIVE_LOW)
    ) u2 (
        .control_clock(clk), .reset(rst), .enable(en),
        .h_sync(u2_hs), .v_sync(u2_vs), .display_enable(u2_de),
        .h_pos(u2_hp), .v_pos(u2_vp), .line_start(u2_ls), .frame_start(u2_fs)
    );

    typedef struct packed {
        logic        hs, vs, de, ls, fs;
        logic [10:0] hp, vp;
    } obs_t;

    typedef struct {
        int   dut;
        obs_t o;
    } sb_t;

    sb_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    int   m_ha[3]   = '{640, 800, 8};
    int   m_hf[3]   = '{16, 56, 2};
    int   m_hs[3]   = '{96, 120, 3};
    int   m_hb[3]   = '{48, 64, 3};
    int   m_va[3]   = '{480, 600, 5};
    int   m_vf[3]   = '{10, 37, 1};
    int   m_vs[3]   = '{2, 6, 2};
    int   m_vb[3]   = '{33, 23, 3};
    logic m_hpol[3] = '{1'b0, 1'b1, 1'b1};
    logic m_vpol[3] = '{1'b0, 1'b1, 1'b0};
    int   mh[3];
    int   mv[3];

    // Expected pulse shape for the two full-size modes, in enabled edges.
    int   hs_start[2]  = '{656, 856};
    int   hs_width[2]  = '{96, 120};
    int   hs_period[2] = '{800, 1040};
    logic prev_act[2]  = '{1'b0, 1'b0};
    logic have_fall[2] = '{1'b0, 1'b0};
    int   fall_cyc[2]  = '{0, 0};

    int   cyc = 0;
    int   mult = 1;
    logic u2_have = 1'b0;
    logic prev_fs2 = 1'b0;
    logic prev_vs2 = 1'b1;
    int   u2_last_fs = 0;
    int   u2_de_cnt = 0;
    int   prev_h2 = 0;
    int   prev_v2 = 0;

    function automatic obs_t model(int d);
        obs_t o;
        int hss = m_ha[d] + m_hf[d];
        int vss = m_va[d] + m_vf[d];
        o.hp = 11'(mh[d]);
        o.vp = 11'(mv[d]);
        o.hs = (mh[d] >= hss && mh[d] < hss + m_hs[d]) ? m_hpol[d] : ~m_hpol[d];
        o.vs = (mv[d] >= vss && mv[d] < vss + m_vs[d]) ? m_vpol[d] : ~m_vpol[d];
        o.de = (mh[d] < m_ha[d]) && (mv[d] < m_va[d]);
        o.ls = (mh[d] == 0);
        o.fs = (mh[d] == 0) && (mv[d] == 0);
        return o;
    endfunction

    function automatic obs_t observe(int d);
        obs_t o;
        case (d)
            0: begin
                o.hs = u0_hs; o.vs = u0_vs; o.de = u0_de; o.ls = u0_ls; o.fs = u0_fs;
                o.hp = u0_hp; o.vp = u0_vp;
            end
            1: begin
                o.hs = u1_hs; o.vs = u1_vs; o.de = u1_de; o.ls = u1_ls; o.fs = u1_fs;
                o.hp = u1_hp; o.vp = u1_vp;
            end
            default: begin
                o.hs = u2_hs; o.vs = u2_vs; o.de = u2_de; o.ls = u2_ls; o.fs = u2_fs;
                o.hp = 11'(u2_hp); o.vp = 11'(u2_vp);
            end
        endcase
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mh[d] = m_ha[d] + m_hf[d] + m_hs[d] + m_hb[d] - 1;
            mv[d] = m_va[d] + m_vf[d] + m_vs[d] + m_vb[d] - 1;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int ht = m_ha[d] + m_hf[d] + m_hs[d] + m_hb[d];
            int vt = m_va[d] + m_vf[d] + m_vs[d] + m_vb[d];
            if (mh[d] == ht - 1) begin
                mh[d] = 0;
                mv[d] = (mv[d] == vt - 1) ? 0 : mv[d] + 1;
            end else begin
                mh[d] = mh[d] + 1;
            end
        end
    endtask

    task automatic push_all();
        for (int d = 0; d < 3; d++) sb.push_back('{dut: d, o: model(d)});
    endtask

    task automatic drain(string tag);
        while (sb.size() > 0) begin
            sb_t  e = sb.pop_front();
            obs_t a = observe(e.dut);
            n_assert++;
            assert (a === e.o) else begin
                n_fail++;
                $error("FAIL %s dut%0d: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                       tag, e.dut, a.hp, a.vp, a.hs, a.vs, a.de, a.ls, a.fs,
                       e.o.hp, e.o.vp, e.o.hs, e.o.vs, e.o.de, e.o.ls, e.o.fs);
            end
        end
    endtask

    task automatic chk(string tag, int act, int exp);
        n_assert++;
        assert (act == exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else if (en) model_step();
        push_all();
        @(negedge clk);
        drain("cycle");
    endtask

    task automatic clear_meas();
        have_fall = '{1'b0, 1'b0};
        u2_have   = 1'b0;
    endtask

    task automatic monitor();
        obs_t o;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic a;
            o = observe(d);
            a = (o.hs == m_hpol[d]);
            if (a && !prev_act[d]) begin
                chk($sformatf("hs_start_dut%0d", d), int'(o.hp), hs_start[d]);
                if (have_fall[d]) chk($sformatf("hs_period_dut%0d", d), cyc - fall_cyc[d], hs_period[d] * mult);
                fall_cyc[d]  = cyc;
                have_fall[d] = 1'b1;
            end
            if (!a && prev_act[d] && have_fall[d])
                chk($sformatf("hs_width_dut%0d", d), cyc - fall_cyc[d], hs_width[d] * mult);
            prev_act[d] = a;
        end
        o = observe(2);
        chk("u2_v_bound", int'(o.vp < 11), 1);
        if (o.fs && !prev_fs2) begin
            chk("u2_fs_with_ls", int'(o.ls), 1);
            if (u2_have) begin
                chk("u2_de_per_frame", u2_de_cnt, 40 * mult);
                chk("u2_frame_period", cyc - u2_last_fs, 176 * mult);
            end
            u2_have    = 1'b1;
            u2_last_fs = cyc;
            u2_de_cnt  = 0;
        end
        if (o.de) u2_de_cnt++;
        if (!o.vs && prev_vs2) begin
            chk("u2_vs_edge_h", int'(o.hp), 0);
            chk("u2_vs_edge_v", int'(o.vp), 6);
        end
        if (prev_h2 == 15 && prev_v2 == 5 && (int'(o.hp) != prev_h2)) begin
            chk("u2_wrap_h", int'(o.hp), 0);
            chk("u2_wrap_v", int'(o.vp), 6);
        end
        prev_fs2 = o.fs;
        prev_vs2 = o.vs;
        prev_h2  = int'(o.hp);
        prev_v2  = int'(o.vp);
    endtask

    task automatic run(int n, bit toggle);
        for (int i = 0; i < n; i++) begin
            tick();
            monitor();
            if (toggle) en = ~en;
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        en  = 1'b0;
        #2;
        model_reset();
        push_all();
        drain("reset");
        en = 1'b1;
        run(3, 1'b0);

        // First enabled edge after release wraps every instance to (0,0).
        rst = 1'b0;
        run(1, 1'b0);
        chk("first_fs_u0", int'(u0_fs), 1);
        chk("first_h_u0", int'(u0_hp), 0);
        chk("first_v_u2", int'(u2_vp), 0);

        mult = 1;
        clear_meas();
        run(2400, 1'b0);

        mult = 2;
        clear_meas();
        en = 1'b1;
        run(3400, 1'b1);

        mult = 1;
        clear_meas();
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            monitor();
            if (u0_hp == 11'd700) found = 1'b1;
        end
        if (!found) begin
            n_fail++;
            $display("FAIL reach_h700: timed out waiting for h_pos=700");
        end

        // Reset in the middle of the horizontal sync pulse, away from any clock edge.
        #1;
        rst = 1'b1;
        clear_meas();
        #1;
        model_reset();
        push_all();
        drain("mid_reset");
        chk("hs_async_u0", int'(u0_hs), 1);
        run(1, 1'b0);
        rst = 1'b0;
        run(1, 1'b0);
        chk("post_reset_fs_u0", int'(u0_fs), 1);
        chk("post_reset_h_u0", int'(u0_hp), 0);

        run(1100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
